// File: rtl/rock_pkg.sv
// Shared definitions for the cradle rocking strategy: index layout, FSM encoding,
// and the small helpers used by the ramp and the candidate walk.
package rock_pkg;

    localparam int IDX_W = 6;
    localparam int FLD_W = 3;
    localparam logic [IDX_W-1:0] IDX_OFF = 6'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_EVAL,
        ST_DECIDE
    } rock_state_e;

    function automatic logic [FLD_W-1:0] step_toward(input logic [FLD_W-1:0] cur,
                                                     input logic [FLD_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + 1'b1;
        end else if (cur > tgt) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

    // The walk skips index 0 so "motor stopped" is never offered as a candidate.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == '1) ? IDX_W'(1) : i + 1'b1;
    endfunction

endpackage

// File: rtl/rock_strategy_if.sv
// Stress verdicts in, motor setpoints and search status out. The slave side is the
// strategy block; the master side is whatever feeds it (stress stage, timebase, enable).
interface rock_strategy_if;
    import rock_pkg::*;

    logic             slowClk;
    logic             enable;
    logic             stressLaag;
    logic             stressGelijk;
    logic [FLD_W-1:0] freq;
    logic [FLD_W-1:0] amp;
    logic             motorAan;
    logic             changed;
    logic [IDX_W-1:0] bestIdx;

    modport master (
        output slowClk, enable, stressLaag, stressGelijk,
        input  freq, amp, motorAan, changed, bestIdx
    );

    modport slave (
        input  slowClk, enable, stressLaag, stressGelijk,
        output freq, amp, motorAan, changed, bestIdx
    );

endinterface

// File: rtl/slow_tick.sv
// Brings the slow timebase level into the clk domain and turns each rising edge into
// a single-clk tick pulse. Shared by every slow-domain consumer.
module slow_tick (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic tick
);

    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value; blocking here would collapse the shift chain into one stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], level};
        end
    end

    assign tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/rock_strategy.sv
// Search over {freq,amp} rocking settings driven by stress verdicts: keep improvements,
// revert on rising stress, move on after a stagnant run. Setpoints slew one LSB per tick.
module rock_strategy
    import rock_pkg::*;
#(
    parameter int               EVAL_TICKS   = 8,
    parameter int               STABLE_EVALS = 4,
    parameter logic [IDX_W-1:0] START_IDX    = 6'd9
) (
    input logic            clk,
    input logic            reset,
    rock_strategy_if.slave bus
);

    localparam int WIN_W = (EVAL_TICKS > 1) ? $clog2(EVAL_TICKS) : 1;
    localparam int EQ_W  = $clog2(STABLE_EVALS + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(EVAL_TICKS - 1);
    localparam logic [EQ_W-1:0]  EQ_LAST  = EQ_W'(STABLE_EVALS);

    rock_state_e      state_q, state_d;
    logic [IDX_W-1:0] tgt_q, tgt_d;
    logic [IDX_W-1:0] best_q, best_d;
    logic [FLD_W-1:0] freq_q, amp_q;
    logic [WIN_W-1:0] win_q, win_d;
    logic [EQ_W-1:0]  eq_q, eq_d, eq_inc;
    logic             laag_q, laag_d;
    logic             gelijk_q, gelijk_d;
    logic             changed_q, changed_d;
    logic             tick;
    logic             settled;

    slow_tick u_tick (
        .clk   (clk),
        .reset (reset),
        .level (bus.slowClk),
        .tick  (tick)
    );

    // The ramp runs in every state, so a disabled motor still winds down gently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_q <= '0;
            amp_q  <= '0;
        end else if (tick) begin
            freq_q <= step_toward(freq_q, tgt_q[IDX_W-1:FLD_W]);
            amp_q  <= step_toward(amp_q, tgt_q[FLD_W-1:0]);
        end
    end

    assign settled = ({freq_q, amp_q} == tgt_q);
    assign eq_inc  = eq_q + 1'b1;

    // NOTE: every signal written below gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        best_d    = best_q;
        win_d     = win_q;
        eq_d      = eq_q;
        laag_d    = laag_q;
        gelijk_d  = gelijk_q;
        changed_d = 1'b0;

        if (!bus.enable) begin
            // Disable outranks a coincident tick: no window or decision update.
            state_d = ST_IDLE;
            tgt_d   = IDX_OFF;
            win_d   = '0;
            eq_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_d   = ST_RAMP;
                        tgt_d     = START_IDX;
                        changed_d = 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (settled) begin
                        state_d = ST_EVAL;
                        win_d   = '0;
                    end
                end
                ST_EVAL: begin
                    if (tick) begin
                        if (win_q == WIN_LAST) begin
                            laag_d   = bus.stressLaag;
                            gelijk_d = bus.stressGelijk;
                            win_d    = '0;
                            state_d  = ST_DECIDE;
                        end else begin
                            win_d = win_q + 1'b1;
                        end
                    end
                end
                ST_DECIDE: begin
                    if (laag_q) begin
                        best_d  = tgt_q;
                        eq_d    = '0;
                        state_d = ST_EVAL;
                    end else if (gelijk_q) begin
                        if (eq_inc == EQ_LAST) begin
                            eq_d      = '0;
                            tgt_d     = next_idx(tgt_q);
                            changed_d = 1'b1;
                            state_d   = ST_RAMP;
                        end else begin
                            eq_d    = eq_inc;
                            state_d = ST_EVAL;
                        end
                    end else begin
                        // Stress rose: fall back to the best known setting unless we are on it.
                        tgt_d     = (best_q != IDX_OFF && best_q != tgt_q) ? best_q : next_idx(tgt_q);
                        changed_d = 1'b1;
                        eq_d      = '0;
                        state_d   = ST_RAMP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tgt_q     <= IDX_OFF;
            best_q    <= IDX_OFF;
            win_q     <= '0;
            eq_q      <= '0;
            laag_q    <= 1'b0;
            gelijk_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            best_q    <= best_d;
            win_q     <= win_d;
            eq_q      <= eq_d;
            laag_q    <= laag_d;
            gelijk_q  <= gelijk_d;
            changed_q <= changed_d;
        end
    end

    assign bus.freq     = freq_q;
    assign bus.amp      = amp_q;
    assign bus.motorAan = (state_q != ST_IDLE);
    assign bus.changed  = changed_q;
    assign bus.bestIdx  = best_q;

endmodule

// File: tb/tb_rock_strategy.sv
// Randomized bench for rock_strategy against a tick-level model of the search rules.
module tb_rock_strategy;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_EVAL = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rock_strategy_if bus ();

    rock_strategy dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int chg_seen = 0;

    // Model state: applied setpoint, target, best, counters, search phase.
    int m_f, m_a, m_tgt, m_best, m_eq, m_win, m_st, m_chg;
    bit m_en, m_laag, m_gel;
    bit wrapped;

    always @(negedge clk) begin
        if (!reset && bus.changed === 1'b1) chg_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int toward(input int cur, input int tgt);
        if (cur < tgt) return cur + 1;
        if (cur > tgt) return cur - 1;
        return cur;
    endfunction

    function automatic int nxt(input int i);
        return (i >= 63) ? 1 : i + 1;
    endfunction

    task automatic model_reset();
        m_f = 0; m_a = 0; m_tgt = 0; m_best = 0; m_eq = 0; m_win = 0; m_st = M_IDLE;
    endtask

    task automatic model_resolve();
        if (m_laag) begin
            m_best = m_tgt; m_eq = 0; m_st = M_EVAL;
        end else if (m_gel) begin
            m_eq++;
            if (m_eq == 4) begin
                m_eq = 0;
                if (m_tgt == 63) wrapped = 1'b1;
                m_tgt = nxt(m_tgt); m_chg++; m_st = M_RAMP;
            end else begin
                m_st = M_EVAL;
            end
        end else begin
            if (m_best != 0 && m_best != m_tgt) m_tgt = m_best;
            else m_tgt = nxt(m_tgt);
            m_chg++; m_eq = 0; m_st = M_RAMP;
        end
    endtask

    task automatic model_tick();
        m_f = toward(m_f, m_tgt / 8);
        m_a = toward(m_a, m_tgt % 8);
        if (m_en) begin
            if (m_st == M_IDLE) begin
                m_tgt = 9; m_chg++; m_st = M_RAMP;
            end else if (m_st == M_EVAL) begin
                if (m_win == 7) begin
                    m_win = 0;
                    model_resolve();
                end else begin
                    m_win++;
                end
            end
        end
        if (m_st == M_RAMP && (m_f * 8 + m_a) == m_tgt) begin
            m_st = M_EVAL; m_win = 0;
        end
    endtask

    // One 16-clk slow period: high half carries the tick, low half applies new stimulus.
    task automatic period(input bit laag, input bit gel, input bit en, input bit rst_now);
        int base;
        base = chg_seen;
        m_chg = 0;
        bus.slowClk = 1'b1;
        model_tick();
        repeat (8) @(posedge clk);
        #1;
        check("freq", bus.freq, m_f);
        check("amp", bus.amp, m_a);
        check("bestIdx", bus.bestIdx, m_best);
        check("motorAan", bus.motorAan, (m_st != M_IDLE));
        check("changed_pulses", chg_seen - base, m_chg);

        bus.slowClk      = 1'b0;
        bus.stressLaag   = laag;
        bus.stressGelijk = gel;
        m_laag = laag;
        m_gel  = gel;
        if (m_en && !en) begin
            m_st = M_IDLE; m_tgt = 0; m_win = 0; m_eq = 0;
        end
        bus.enable = en;
        m_en = en;

        if (rst_now) begin
            @(posedge clk);
            #2 reset = 1'b1;
            #1;
            check("rst_freq", bus.freq, 0);
            check("rst_amp", bus.amp, 0);
            check("rst_bestIdx", bus.bestIdx, 0);
            check("rst_motorAan", bus.motorAan, 0);
            check("rst_changed", bus.changed, 0);
            @(posedge clk);
            #1 reset = 1'b0;
            model_reset();
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit en_r, rst_done, l, g;
        int r;

        reset = 1'b1;
        bus.slowClk = 1'b0;
        bus.enable = 1'b0;
        bus.stressLaag = 1'b0;
        bus.stressGelijk = 1'b0;
        m_en = 1'b0; m_laag = 1'b0; m_gel = 1'b0; wrapped = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_freq", bus.freq, 0);
        check("reset_amp", bus.amp, 0);
        check("reset_bestIdx", bus.bestIdx, 0);
        check("reset_motorAan", bus.motorAan, 0);
        check("reset_changed", bus.changed, 0);
        reset = 1'b0;

        // Start rocking with stress steadily dropping.
        bus.enable = 1'b1; bus.stressLaag = 1'b1;
        m_en = 1'b1; m_laag = 1'b1;
        repeat (12) period(1'b1, 1'b0, 1'b1, 1'b0);
        check("first_best", bus.bestIdx, 9);
        check("first_setpoint", {bus.freq, bus.amp}, 9);

        // Steady verdicts walk the candidates all the way around the wrap.
        n = 0;
        while (!(wrapped && m_tgt == 2) && n < 3000) begin
            period(1'b0, 1'b1, 1'b1, 1'b0);
            n++;
        end
        check("wrap_reached", (wrapped && m_tgt == 2), 1);

        // Random verdicts with occasional disables and one async reset mid-ramp.
        en_r = 1'b1;
        rst_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            l = (r <= 3);
            g = (r >= 3 && r <= 7);
            if (en_r) en_r = ($urandom_range(0, 24) != 0);
            else      en_r = ($urandom_range(0, 3) == 0);
            period(l, g, en_r, (!rst_done && i >= 150 && (m_f != 0 || m_a != 0)));
            if (i >= 150 && (m_f != 0 || m_a != 0)) rst_done = 1'b1;
        end
        check("reset_exercised", rst_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
